// File: rtl/sync_timer_pkg.sv
// Shared types and width helpers for the sync-pattern delay timer.
package sync_timer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_timer_down_counter.sv
// Two-level down counter: an inner prescaler of CNT_PER cycles per delay unit
// and an outer count of remaining delay units.
module sync_timer_down_counter #(
  parameter int unsigned DLY_W   = 4,
  parameter int unsigned CNT_PER = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DLY_W-1:0] delay_in,
  input  logic             enable,
  output logic [DLY_W-1:0] count,
  output logic             expired
);
  import sync_timer_pkg::*;

  localparam int unsigned CW = width_of(CNT_PER);
  localparam logic [CW-1:0] INNER_MAX = CW'(CNT_PER - 1);

  logic [CW-1:0] inner;

  // Load both levels together; the outer count only moves when the inner
  // prescaler wraps, and it holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      inner <= '0;
    end else if (load) begin
      count <= delay_in;
      inner <= INNER_MAX;
    end else if (enable) begin
      if (inner != '0) begin
        inner <= inner - CW'(1);
      end else if (count != '0) begin
        count <= count - DLY_W'(1);
        inner <= INNER_MAX;
      end
    end
  end

  // Last cycle of the final delay unit.
  assign expired = (inner == '0) && (count == '0);

endmodule

// File: rtl/sync_timer_fsm.sv
// Serial sync-pattern detector that captures a delay field and then times
// (delay+1)*CNT_PER cycles before signalling done until acknowledged.
module sync_timer_fsm #(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PAT     = 4'b1101,
  parameter int unsigned           DLY_W   = 4,
  parameter int unsigned           CNT_PER = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             ack,
  output logic             shift_ena,
  output logic             counting,
  output logic             done,
  output logic [DLY_W-1:0] count
);
  import sync_timer_pkg::*;

  localparam int unsigned FW = width_of(PAT_W);
  localparam int unsigned BW = width_of(DLY_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DLY_W - 1);

  state_e           state_q, state_d;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;
  logic             match;
  logic [DLY_W-1:0] delay_sr, delay_next;
  logic [BW-1:0]    bit_cnt;
  logic             last_bit;
  logic             cnt_load, cnt_enable, cnt_expired;
  logic             shift_ena_d, counting_d, done_d;

  // Fill guard keeps the cleared history from completing a pattern.
  assign window     = {hist, data};
  assign match      = (window == PAT) && (fill >= FILL_MAX);
  assign delay_next = (delay_sr << 1) | DLY_W'(data);
  assign last_bit   = (bit_cnt == LAST_BIT);

  // Next state, counter controls and next output values.
  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_enable  = 1'b0;
    shift_ena_d = 1'b0;
    counting_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      SEARCH: if (match) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          state_d  = COUNT;
          cnt_load = 1'b1;
        end
      end
      COUNT: begin
        cnt_enable = 1'b1;
        if (cnt_expired) state_d = DONE;
      end
      DONE: if (ack) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
    shift_ena_d = (state_d == SHIFT);
    counting_d  = (state_d == COUNT);
    done_d      = (state_d == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // Registered Moore outputs, aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_ena <= 1'b0;
      counting  <= 1'b0;
      done      <= 1'b0;
    end else begin
      shift_ena <= shift_ena_d;
      counting  <= counting_d;
      done      <= done_d;
    end
  end

  // Pattern history; only accumulates in SEARCH, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (reset || (state_q != SEARCH)) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= window[PAT_W-2:0];
      if (fill != FILL_MAX) fill <= fill + FW'(1);
    end
  end

  // Delay field capture, MSB first, one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_sr <= '0;
      bit_cnt  <= '0;
    end else if (state_q == SHIFT) begin
      delay_sr <= delay_next;
      bit_cnt  <= last_bit ? '0 : bit_cnt + BW'(1);
    end else begin
      bit_cnt  <= '0;
    end
  end

  sync_timer_down_counter #(
    .DLY_W  (DLY_W),
    .CNT_PER(CNT_PER)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .delay_in(delay_next),
    .enable  (cnt_enable),
    .count   (count),
    .expired (cnt_expired)
  );

endmodule

// File: tb/tb_sync_timer_fsm.sv
// Directed bench for sync_timer_fsm: three instances cover the default
// pattern, an alternate pattern and a single-cycle delay unit.
module tb_sync_timer_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data = 1'b0;
  logic ack = 1'b0;

  logic       m_shift_ena, m_counting, m_done;
  logic [3:0] m_count;
  logic       p_shift_ena, p_counting, p_done;
  logic [3:0] p_count;
  logic       c_shift_ena, c_counting, c_done;
  logic [3:0] c_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  always #5 clk = ~clk;

  sync_timer_fsm #(.PAT_W(4), .PAT(4'b1101), .DLY_W(4), .CNT_PER(4)) u_main (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
    .shift_ena(m_shift_ena), .counting(m_counting), .done(m_done), .count(m_count)
  );

  sync_timer_fsm #(.PAT_W(4), .PAT(4'b0011), .DLY_W(4), .CNT_PER(4)) u_pat (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
    .shift_ena(p_shift_ena), .counting(p_counting), .done(p_done), .count(p_count)
  );

  sync_timer_fsm #(.PAT_W(4), .PAT(4'b1101), .DLY_W(4), .CNT_PER(1)) u_c1 (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
    .shift_ena(c_shift_ena), .counting(c_counting), .done(c_done), .count(c_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    data = b;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send(w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data  = 1'b0;
    ack   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Cycles spent with counting high, starting from the current sample.
  task automatic count_len(input int which, output int len);
    len = 0;
    while (((which == 0) ? m_counting : c_counting) === 1'b1 && len < 200) begin
      tick();
      len++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_shift_ena", 32'(m_shift_ena), 32'd0);
    check("rst_counting",  32'(m_counting),  32'd0);
    check("rst_done",      32'(m_done),      32'd0);
    check("rst_count",     32'(m_count),     32'd0);

    // 1101 then delay 0101: shift 4 cycles, count 5..0 over 24 cycles
    send(1'b1); check("a_bit1", 32'(m_shift_ena), 32'd0);
    send(1'b1); check("a_bit2", 32'(m_shift_ena), 32'd0);
    send(1'b0); check("a_bit3", 32'(m_shift_ena), 32'd0);
    send(1'b1); check("a_shift_on", 32'(m_shift_ena), 32'd1);
    send(1'b0); check("a_shift_2", 32'(m_shift_ena), 32'd1);
    send(1'b1); check("a_shift_3", 32'(m_shift_ena), 32'd1);
    send(1'b0); check("a_shift_4", 32'(m_shift_ena), 32'd1);
    send(1'b1); check("a_shift_off", 32'(m_shift_ena), 32'd0);
    check("a_counting_on", 32'(m_counting), 32'd1);
    n = 0;
    while (m_counting === 1'b1 && n < 100) begin
      check("a_count_val", 32'(m_count), 32'(5 - n / 4));
      tick();
      n++;
    end
    check("a_count_len", 32'(n), 32'd24);
    check("a_done_on", 32'(m_done), 32'd1);
    check("a_count_idle", 32'(m_count), 32'd0);
    repeat (3) tick();
    check("a_done_hold", 32'(m_done), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("a_done_off", 32'(m_done), 32'd0);

    // Overlapping pattern 1,1,1,0,1 then delay 0
    do_reset();
    send(1'b1); send(1'b1); send(1'b1);
    check("b_bit3", 32'(m_shift_ena), 32'd0);
    send(1'b0); check("b_bit4", 32'(m_shift_ena), 32'd0);
    send(1'b1); check("b_overlap_match", 32'(m_shift_ena), 32'd1);
    send_word(4'b0000);
    check("b_count_zero", 32'(m_count), 32'd0);
    count_len(0, n);
    check("b_count_len", 32'(n), 32'd4);
    check("b_done", 32'(m_done), 32'd1);

    // PAT=0011: stale zeros must not complete 1,1
    do_reset();
    send(1'b1); check("c_bit1", 32'(p_shift_ena), 32'd0);
    send(1'b1); check("c_stale_zero", 32'(p_shift_ena), 32'd0);
    send(1'b0); send(1'b0);
    send(1'b1); check("c_bit5", 32'(p_shift_ena), 32'd0);
    send(1'b1); check("c_match", 32'(p_shift_ena), 32'd1);

    // Reset in the 10th COUNT cycle
    do_reset();
    send_word(4'b1101);
    send_word(4'b0101);
    repeat (9) tick();
    check("d_cnt10_counting", 32'(m_counting), 32'd1);
    check("d_cnt10_count", 32'(m_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("d_rst_shift_ena", 32'(m_shift_ena), 32'd0);
    check("d_rst_counting",  32'(m_counting),  32'd0);
    check("d_rst_done",      32'(m_done),      32'd0);
    check("d_rst_count",     32'(m_count),     32'd0);
    send(1'b1); send(1'b0);
    send(1'b1); check("d_partial", 32'(m_shift_ena), 32'd0);
    send(1'b1); send(1'b1); send(1'b0);
    check("d_before_match", 32'(m_shift_ena), 32'd0);
    send(1'b1); check("d_new_match", 32'(m_shift_ena), 32'd1);

    // ack held through SHIFT and COUNT, then one-cycle DONE
    do_reset();
    ack = 1'b1;
    send_word(4'b1101);
    check("e_shift_ack", 32'(m_shift_ena), 32'd1);
    send_word(4'b0000);
    count_len(0, n);
    check("e_count_len_ack", 32'(n), 32'd4);
    check("e_done_first", 32'(m_done), 32'd1);
    tick();
    check("e_done_one_cycle", 32'(m_done), 32'd0);
    ack = 1'b0;

    // Bits streamed in DONE are not part of the next match
    send_word(4'b1101);
    send_word(4'b0000);
    count_len(0, n);
    check("e2_done", 32'(m_done), 32'd1);
    send(1'b1); send(1'b1);
    check("e2_done_hold", 32'(m_done), 32'd1);
    ack = 1'b1;
    send(1'b0);
    ack = 1'b0;
    check("e2_done_off", 32'(m_done), 32'd0);
    send(1'b1);
    check("e2_no_stale_match", 32'(m_shift_ena), 32'd0);

    // CNT_PER=1: delay 0 -> 1 cycle, delay 15 -> 16 cycles
    do_reset();
    send_word(4'b1101);
    send_word(4'b0000);
    count_len(1, n);
    check("f_len_d0", 32'(n), 32'd1);
    check("f_done_d0", 32'(c_done), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    send_word(4'b1101);
    send_word(4'b1111);
    check("f_count15", 32'(c_count), 32'd15);
    count_len(1, n);
    check("f_len_d15", 32'(n), 32'd16);
    check("f_done_d15", 32'(c_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_timer_fsm.md
SYNC_TIMER_FSM -- requirements
Module: sync_timer_fsm

Interface
REQ-001 Parameter PAT_W, default 4: sync pattern length in bits; legal range >= 2.
REQ-002 Parameter PAT, default 4'b1101: sync pattern, PAT_W bits wide; the MSB is received first.
REQ-003 Parameter DLY_W, default 4: width of the serially loaded delay field; legal range >= 1.
REQ-004 Parameter CNT_PER, default 1000: cycles per delay unit; legal range >= 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data  input  1  serial input: carries the pattern, then the delay field (MSB first).
REQ-008 ack  input  1  acknowledges completion; sampled only in DONE.
REQ-009 shift_ena  output  1  high while delay bits are being captured.
REQ-010 counting  output  1  high while the timer runs.
REQ-011 done  output  1  high while waiting for ack.
REQ-012 count  output  DLY_W  remaining delay units during COUNT; 0 in all other states.

Function
REQ-013 States SHALL be SEARCH, SHIFT, COUNT, DONE; all outputs SHALL be Moore, decoded from registered state only.
REQ-014 SEARCH: history register hist (PAT_W-1 bits) and a saturating fill counter SHALL record the bits received since SEARCH was entered.
REQ-015 A match SHALL require {hist, data} == PAT and fill >= PAT_W-1, so stale zeros can never complete a pattern.
- On match, the next state SHALL be SHIFT.
REQ-016 Pattern search SHALL tolerate overlap: the history keeps shifting on a mismatch, so 1,1,1,0,1 matches PAT=1101 on the final bit.
REQ-017 SHIFT: shift_ena=1 for exactly DLY_W cycles.
- Each of those cycles: delay <= {delay[DLY_W-2:0], data}.
- After the DLY_W-th bit: go to COUNT with the inner counter loaded to CNT_PER-1.
REQ-018 COUNT: counting=1 and count=delay.
- Each cycle the inner counter SHALL decrement.
- At inner counter 0 with delay>0: decrement delay and reload the inner counter to CNT_PER-1.
- At inner counter 0 with delay==0: go to DONE.
REQ-019 COUNT SHALL last exactly (delay+1)*CNT_PER cycles; for delay=0, CNT_PER=1 that is one cycle.
REQ-020 DONE: done=1 until ack=1 is sampled; the next state is then SEARCH with hist and fill cleared.
REQ-021 data SHALL be ignored in COUNT and DONE; ack SHALL be ignored outside DONE.
REQ-022 Pattern bits arriving while in DONE SHALL NOT count toward the next match.
REQ-023 Counter widths SHALL be clog2(CNT_PER), minimum 1; delay arithmetic SHALL never wrap below 0.
REQ-024 Outputs SHALL never be X after the first reset.

Reset
REQ-025 reset=1 at a clock edge SHALL force SEARCH and clear hist, fill, delay and the inner counter.
- Next-cycle outputs: shift_ena=0, counting=0, done=0, count=0.
REQ-026 Reset SHALL take priority over every transition, including reset mid-SHIFT, mid-COUNT and in DONE together with ack=1.

Structure
REQ-027 Package sync_timer_pkg SHALL hold the state enum type (SEARCH, SHIFT, COUNT, DONE) and the clog2-based width helper.
REQ-028 The two-level counter SHALL be the sub-module sync_timer_down_counter.
- Inputs: load, delay value, enable.
- Outputs: count, expired.
REQ-029 The FSM and the pattern matcher SHALL remain in sync_timer_fsm.

Verification (PAT=1101, DLY_W=4, CNT_PER=4 unless stated)
REQ-030 After reset, data=1,1,0,1 then 0,1,0,1 -> shift_ena high for exactly 4 cycles; counting high 24 cycles; count reads 5,4,3,2,1,0 for 4 cycles each; done stays high until ack.
REQ-031 data=1,1,1,0,1,0,0,0,0 -> shift_ena rises the cycle after the 5th bit; delay=0; counting for 4 cycles.
REQ-032 PAT=4'b0011: reset, then data=1,1 -> no match; then 0,0,1,1 -> match.
REQ-033 Reset asserted in the 10th COUNT cycle -> the next cycle shows all outputs 0 and the state is SEARCH; a new 1101 is then required.
REQ-034 ack=1 held through SHIFT and COUNT -> no effect; ack=1 in the first DONE cycle -> done high for exactly 1 cycle; a pattern streamed during DONE is not matched.
REQ-035 CNT_PER=1, delay=0 -> counting high for exactly 1 cycle; CNT_PER=1, delay=15 -> counting high for exactly 16 cycles.
